// File: rtl/pd_pkg.sv
// Shared types and reset-time configuration for the pattern detection controller.
package pd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int   PD_MAX_LEN  = 8;
  localparam int   RST_PATTERN = 'b1010;
  localparam int   RST_LEN     = 4;
  localparam logic RST_OVERLAP = 1'b1;

endpackage

// File: rtl/pattern_detect_ctrl_core.sv
// History shift register, fill counter and length-masked compare for one serial pattern.
module pattern_match_core
  import pd_pkg::*;
#(
  parameter int MAX_LEN = PD_MAX_LEN,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               in_bit,
  input  logic               clr,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  // The incoming bit completes the window, so a hit needs only len-1 bits of prior history.
  always_comb begin
    window = {hist_q, in_bit};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (fill_q >= (len - LEN_W'(1))) &&
          ((window & mask) == (pattern & mask));
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = window[MAX_LEN-2:0];
      if (fill_q < len) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Run controller: configuration registers, run FSM, beat window and saturating match counter.
module pattern_detect_ctrl
  import pd_pkg::*;
#(
  parameter int MAX_LEN = PD_MAX_LEN,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic [WIN_W-1:0]   win_len,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               in_ready,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]   beats_q, beats_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               cfg_err_q, cfg_err_d;

  logic beat, hit, start_run, cfg_ok, last_beat, core_clr;

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign match     = hit;
  assign match_cnt = cnt_q;
  assign cfg_err   = cfg_err_q;

  assign beat      = in_valid & in_ready;
  assign start_run = (state_q != RUN) & start & ~abort;
  assign cfg_ok    = (state_q != RUN) && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign last_beat = beat && (win_q != '0) && (beats_q == win_q - WIN_W'(1));
  // Non-overlap mode forgets the bits of a match so they cannot seed the next one.
  assign core_clr  = start_run | (hit & ~ovl_q);

  pattern_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (beat),
    .in_bit   (in_bit),
    .clr      (core_clr),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    win_d     = win_q;
    cfg_err_d = cfg_we & ~cfg_ok;

    if (cfg_we && cfg_ok) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      ovl_d = cfg_overlap;
    end

    if (beat) begin
      beats_d = beats_q + WIN_W'(1);
    end
    if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start_run) begin
          state_d = RUN;
          cnt_d   = '0;
          beats_d = '0;
          win_d   = win_len;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_beat) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= MAX_LEN'(RST_PATTERN);
      len_q     <= LEN_W'(RST_LEN);
      ovl_q     <= RST_OVERLAP;
      cnt_q     <= '0;
      beats_q   <= '0;
      win_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
      win_q     <= win_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed, table-driven bench for pattern_detect_ctrl; a second instance with a 2-bit counter covers saturation.
module tb_pattern_detect_ctrl;

  typedef struct {
    logic       sel;
    logic       valid;
    logic       b;
    logic       expMatch;
    logic [7:0] expCnt;
    logic       expReady;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_pattern = '0;
  logic [3:0]  cfg_len = '0;
  logic        cfg_overlap = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] win_len = '0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;

  logic       cfgErrA, readyA, matchA, busyA, doneA;
  logic [7:0] cntA;
  logic       cfgErrB, readyB, matchB, busyB, doneB;
  logic [1:0] cntB;

  int   totalChecks = 0;
  int   passedChecks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pattern_detect_ctrl dutA (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(cfgErrA), .start(start), .abort(abort),
    .win_len(win_len), .in_valid(in_valid), .in_bit(in_bit), .in_ready(readyA),
    .match(matchA), .match_cnt(cntA), .busy(busyA), .done(doneA)
  );

  pattern_detect_ctrl #(.CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(cfgErrB), .start(start), .abort(abort),
    .win_len(win_len), .in_valid(in_valid), .in_bit(in_bit), .in_ready(readyB),
    .match(matchB), .match_cnt(cntB), .busy(busyB), .done(doneB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      passedChecks++;
    end
  endtask

  task automatic addVec(input logic s, input logic v, input logic b, input logic m,
                        input logic [7:0] c, input logic r);
    vec_t x;
    x.sel = s; x.valid = v; x.b = b; x.expMatch = m; x.expCnt = c; x.expReady = r;
    vecs.push_back(x);
  endtask

  // Drive one table row at the falling edge, check Mealy match, then registered state after the edge.
  task automatic applyStimulus(input int first, input int last, input string tag);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      in_valid = vecs[i].valid;
      in_bit   = vecs[i].b;
      #1;
      checkOutput($sformatf("%s_match[%0d]", tag, i - first),
                  vecs[i].sel ? matchB : matchA, vecs[i].expMatch);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_cnt[%0d]", tag, i - first),
                  vecs[i].sel ? {6'd0, cntB} : cntA, vecs[i].expCnt);
      checkOutput($sformatf("%s_ready[%0d]", tag, i - first),
                  vecs[i].sel ? readyB : readyA, vecs[i].expReady);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic startRun(input logic [15:0] w);
    @(negedge clk);
    start = 1'b1;
    win_len = w;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busyA, 1'b1);
    checkOutput("done_after_start", doneA, 1'b0);
  endtask

  task automatic abortRun();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("busy_after_abort", busyA, 1'b0);
    checkOutput("done_after_abort", doneA, 1'b0);
  endtask

  task automatic writeCfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic expErr);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_pattern = p;
    cfg_len = l;
    cfg_overlap = o;
    @(negedge clk);
    cfg_we = 1'b0;
    checkOutput("cfg_err_pulse", cfgErrA, expErr);
    @(negedge clk);
    checkOutput("cfg_err_clear", cfgErrA, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s1, s2, s3, s4, s6a, s6b, sEnd;

    s1 = vecs.size();
    addVec(0,1,1,0,0,1); addVec(0,1,0,0,0,1); addVec(0,1,1,0,0,1);
    addVec(0,1,0,1,1,1); addVec(0,1,1,0,1,1); addVec(0,1,0,1,2,1);
    s2 = vecs.size();
    addVec(0,1,1,0,0,1); addVec(0,1,0,0,0,1); addVec(0,1,1,0,0,1); addVec(0,1,0,1,1,1);
    addVec(0,1,1,0,1,1); addVec(0,1,0,0,1,1); addVec(0,1,1,0,1,1); addVec(0,1,0,1,2,1);
    s3 = vecs.size();
    addVec(0,1,1,0,0,1); addVec(0,0,0,0,0,1); addVec(0,1,0,0,0,1); addVec(0,1,1,0,0,1);
    addVec(0,0,0,0,0,1); addVec(0,1,0,1,1,1); addVec(0,1,1,0,1,0); addVec(0,1,0,0,1,0);
    s4 = vecs.size();
    addVec(0,1,1,0,0,1); addVec(0,1,0,0,0,1); addVec(0,1,1,0,0,1); addVec(0,1,0,1,1,1);
    s6a = vecs.size();
    addVec(1,1,1,1,1,1); addVec(1,1,1,1,2,1); addVec(1,1,1,1,3,1);
    addVec(1,1,1,1,3,1); addVec(1,1,1,1,3,1);
    s6b = vecs.size();
    addVec(1,1,1,0,0,1); addVec(1,1,0,0,0,1); addVec(1,1,1,0,0,1);
    addVec(1,1,0,1,1,1); addVec(1,1,1,0,1,1); addVec(1,1,0,1,2,1);
    sEnd = vecs.size();

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", readyA, 1'b0);
    checkOutput("rst_busy", busyA, 1'b0);
    checkOutput("rst_done", doneA, 1'b0);
    checkOutput("rst_cnt", cntA, 8'd0);
    checkOutput("rst_cfg_err", cfgErrA, 1'b0);
    checkOutput("rst_match", matchA, 1'b0);
    rst = 1'b0;

    $display("[TB] test 1: reset config, overlapping 1010");
    startRun(16'd0);
    applyStimulus(s1, s2, "t1");
    checkOutput("t1_busy", busyA, 1'b1);
    checkOutput("t1_done", doneA, 1'b0);

    $display("[TB] test 2: non-overlapping 1010");
    abortRun();
    checkOutput("t2_cnt_held", cntA, 8'd2);
    writeCfg(8'b1010, 4'd4, 1'b0, 1'b0);
    startRun(16'd0);
    checkOutput("t2_cnt_cleared", cntA, 8'd0);
    applyStimulus(s2, s3, "t2");

    $display("[TB] test 3: five-beat window with gaps");
    abortRun();
    startRun(16'd5);
    applyStimulus(s3, s4, "t3");
    checkOutput("t3_done", doneA, 1'b1);
    checkOutput("t3_busy", busyA, 1'b0);

    $display("[TB] test 4: config write rules");
    writeCfg(8'b1010, 4'd4, 1'b1, 1'b0);
    checkOutput("t4_done_kept", doneA, 1'b1);
    startRun(16'd0);
    writeCfg(8'b0101, 4'd4, 1'b1, 1'b1);
    abortRun();
    writeCfg(8'b0101, 4'd0, 1'b1, 1'b1);
    writeCfg(8'b0101, 4'd9, 1'b1, 1'b1);
    startRun(16'd0);
    applyStimulus(s4, s6a, "t4");

    $display("[TB] test 5: abort with start mid-run");
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_busy", busyA, 1'b0);
    checkOutput("t5_done", doneA, 1'b0);
    checkOutput("t5_ready", readyA, 1'b0);
    checkOutput("t5_cnt_held", cntA, 8'd1);
    @(posedge clk);
    #1;
    checkOutput("t5_idle_abort_wins", busyA, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;

    $display("[TB] test 6: 1-bit pattern, 2-bit counter saturation, mid-run reset");
    writeCfg(8'b0000_0001, 4'd1, 1'b1, 1'b0);
    startRun(16'd0);
    applyStimulus(s6a, s6b, "t6");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_bit = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_rst_ready", readyB, 1'b0);
    checkOutput("t6_rst_busy", busyB, 1'b0);
    checkOutput("t6_rst_done", doneB, 1'b0);
    checkOutput("t6_rst_cnt", {6'd0, cntB}, 8'd0);
    checkOutput("t6_rst_cfg_err", cfgErrB, 1'b0);
    checkOutput("t6_rst_match", matchB, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    startRun(16'd0);
    applyStimulus(s6b, sEnd, "t6r");

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
